desc_stream_tx: RTL
===================

Name: desc_stream_tx

Overview:
- Consumer end of the local-descriptor interface.
- Samples the sixteen 64-bit sub-region histogram words and the keypoint address when the descriptor generator raises its completion flag.
- Transmits them as one 17-beat packet on a valid/ready stream toward the descriptor buffer/host path: one header beat followed by 16 descriptor beats.
- Decouples the level-style completion flag of the descriptor generator from a back-pressured downstream sink.

Parameters:
- ADDR_W, 18, keypoint address width.
- CLAMP_VAL, 8'd51, per-bin saturation threshold. 51 is 0.2×255, the SIFT illumination clamp. Used only with DESC_CLAMP_EN.
- HDR_MAGIC, 8'hA5, marker placed in header bits [63:56].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- desc_en  in  1  descriptor-complete flag from the generator. Level signal; a rising edge marks a new descriptor.
- addr_kp  in  ADDR_W  keypoint address belonging to the current descriptor.
- tdesc1..tdesc16  in  64 each  sub-region histograms, 8 bins × 8 bits. Bin 0 is in bits [63:56].
- m_valid  out  1  stream beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_data  out  64  beat payload.
- m_idx  out  5  beat index: 0 = header, 1..16 = tdesc1..tdesc16.
- m_last  out  1  high on beat 16.
- busy  out  1  a packet is captured or in flight.
- desc_done  out  1  one-cycle pulse after beat 16 is accepted.
- err_ovr  out  1  sticky: a rising edge of desc_en arrived while busy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - m_valid, m_data, m_idx, m_last, busy, desc_done, err_ovr and the internal desc_en_d all go to 0.
  - State goes to IDLE. Any in-flight packet is abandoned.
  - Applies mid-packet as well; the next cycle has m_valid=0.
- Edge detect: start = desc_en & ~desc_en_d. desc_en_d is desc_en registered every cycle.
  - Because desc_en_d resets to 0, a desc_en held high across reset release triggers a packet.
- States: IDLE, SEND, DONE.
- IDLE:
  - On start, capture addr_kp and tdesc1..16 into a 16×64 holding register.
  - Next cycle: state SEND, busy=1, m_valid=1, m_idx=0, m_data={HDR_MAGIC, 38'd0, addr_kp}.
  - Latency from the sampled edge to the header on the bus is 1 cycle.
- SEND:
  - Beat k (k = 1..16) has m_data = holding word k.
  - A beat transfers when m_valid & m_ready at a clk edge. After a transfer, m_idx increments and m_data updates in the following cycle.
  - While m_valid & ~m_ready, m_data, m_idx and m_last stay stable and m_valid stays 1.
  - m_last = (m_idx==16).
  - Once asserted for a packet, m_valid stays high until beat 16 transfers; no bubbles even if m_ready toggles every cycle.
  - Throughput is 1 beat/cycle with m_ready held high: 17 cycles per packet.
- Transfer of beat 16: next cycle is state DONE with m_valid=0 and desc_done=1.
- DONE: lasts one cycle, then IDLE with busy=0.
  - A start sampled in the DONE cycle is accepted: capture happens and the header appears on the following cycle.
- start while in SEND:
  - Ignored; the holding register is not overwritten.
  - err_ovr is set to 1 and stays 1 until rst.
- desc_en falling during a packet has no effect.
- The tdesc inputs are not required stable after the capture cycle.

Optional Feature:
- Macro: DESC_CLAMP_EN.
- Defined: at capture, each of the 128 bytes is replaced by min(byte, CLAMP_VAL), unsigned compare. The header is unaffected.
- Undefined: bytes are captured unmodified and the CLAMP_VAL parameter is unused.
- Latency is identical in both builds.

Test Plan:
1. Reset release with desc_en=0; then raise desc_en with addr_kp=18'h1234, tdescK=64'h0101010101010101×K, m_ready=1 → header 64'hA500000000001234 appears 1 cycle later; 16 data beats follow back-to-back; m_last on m_idx=16; desc_done pulses once; busy low 2 cycles after the last beat.
2. Same packet with m_ready = 1,0,0,1 repeating → payload sequence identical to scenario 1; m_data/m_idx hold during every stall; m_valid never drops before beat 16.
3. Raise desc_en for a second time (falling then rising edge) during beat 5 → the packet completes unchanged; err_ovr=1 and stays 1; no second packet follows.
4. Assert rst for one cycle during beat 9 → next cycle m_valid=0, busy=0, err_ovr=0; with desc_en held high, the first post-reset cycle triggers a fresh packet starting at header.
5. With DESC_CLAMP_EN defined, tdesc1=64'hFF33_3400_3210_0A50 → beat 1 = 64'h3333_3300_3210_0A33. Without the macro → beat 1 is unchanged.
6. Rising edge of desc_en sampled in the DONE cycle → the second header follows with no lost packet and err_ovr stays 0.

Source files
------------

// File: rtl/desc_stream_tx.sv
// Descriptor stream transmitter: captures a 16x64 descriptor on a rising edge of desc_en and
// sends it as a header beat plus 16 data beats on a valid/ready stream. Optional macro: DESC_CLAMP_EN.
module desc_stream_tx #(
    parameter int          ADDR_W    = 18,
    parameter logic [7:0]  CLAMP_VAL = 8'd51,
    parameter logic [7:0]  HDR_MAGIC = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              desc_en,
    input  logic [ADDR_W-1:0] addr_kp,
    input  logic [63:0]       tdesc1,
    input  logic [63:0]       tdesc2,
    input  logic [63:0]       tdesc3,
    input  logic [63:0]       tdesc4,
    input  logic [63:0]       tdesc5,
    input  logic [63:0]       tdesc6,
    input  logic [63:0]       tdesc7,
    input  logic [63:0]       tdesc8,
    input  logic [63:0]       tdesc9,
    input  logic [63:0]       tdesc10,
    input  logic [63:0]       tdesc11,
    input  logic [63:0]       tdesc12,
    input  logic [63:0]       tdesc13,
    input  logic [63:0]       tdesc14,
    input  logic [63:0]       tdesc15,
    input  logic [63:0]       tdesc16,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [63:0]       m_data,
    output logic [4:0]        m_idx,
    output logic              m_last,
    output logic              busy,
    output logic              desc_done,
    output logic              err_ovr
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

`ifdef DESC_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif
    // With clamping disabled the limit is 0xFF, which makes the min() an identity.
    localparam logic [7:0] CLAMP_LIM = CLAMP_EN ? CLAMP_VAL : 8'hFF;
    localparam int         PAD_W     = 56 - ADDR_W;

    function automatic logic [63:0] clamp_word(input logic [63:0] w);
        logic [63:0] r;
        r = w;
        for (int b = 0; b < 8; b++) begin
            if (w[b*8 +: 8] > CLAMP_LIM)
                r[b*8 +: 8] = CLAMP_LIM;
        end
        return r;
    endfunction

    state_t      state_reg, state_next;
    logic        en_d_reg;
    logic        valid_reg, valid_next;
    logic [63:0] data_reg, data_next;
    logic [4:0]  idx_reg, idx_next;
    logic        last_reg, last_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        ovr_reg, ovr_next;
    logic        start;
    logic        capture;
    logic [63:0] header;

    logic [63:0] tdesc_in [16];
    logic [63:0] cap_word [16];
    logic [63:0] hold_reg [16];

    assign tdesc_in[0]  = tdesc1;
    assign tdesc_in[1]  = tdesc2;
    assign tdesc_in[2]  = tdesc3;
    assign tdesc_in[3]  = tdesc4;
    assign tdesc_in[4]  = tdesc5;
    assign tdesc_in[5]  = tdesc6;
    assign tdesc_in[6]  = tdesc7;
    assign tdesc_in[7]  = tdesc8;
    assign tdesc_in[8]  = tdesc9;
    assign tdesc_in[9]  = tdesc10;
    assign tdesc_in[10] = tdesc11;
    assign tdesc_in[11] = tdesc12;
    assign tdesc_in[12] = tdesc13;
    assign tdesc_in[13] = tdesc14;
    assign tdesc_in[14] = tdesc15;
    assign tdesc_in[15] = tdesc16;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_cap
            assign cap_word[gi] = clamp_word(tdesc_in[gi]);
        end
    endgenerate

    assign start  = desc_en & ~en_d_reg;
    assign header = {HDR_MAGIC, {PAD_W{1'b0}}, addr_kp};

    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        data_next  = data_reg;
        idx_next   = idx_reg;
        last_next  = last_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        ovr_next   = ovr_reg;
        capture    = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
                // A new edge in the DONE cycle is accepted so back-to-back packets are not lost.
                if (start) begin
                    capture    = 1'b1;
                    state_next = SEND;
                    valid_next = 1'b1;
                    idx_next   = 5'd0;
                    data_next  = header;
                    last_next  = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            SEND: begin
                if (start)
                    ovr_next = 1'b1;
                if (valid_reg && m_ready) begin
                    if (idx_reg == 5'd16) begin
                        state_next = DONE;
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next  = idx_reg + 5'd1;
                        data_next = hold_reg[idx_reg[3:0]];
                        last_next = (idx_reg == 5'd15);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            en_d_reg  <= 1'b0;
            valid_reg <= 1'b0;
            data_reg  <= 64'd0;
            idx_reg   <= 5'd0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            en_d_reg  <= desc_en;
            valid_reg <= valid_next;
            data_reg  <= data_next;
            idx_reg   <= idx_next;
            last_reg  <= last_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            ovr_reg   <= ovr_next;
        end
    end

    // Payload storage carries no reset; it is only read after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < 16; i++)
                hold_reg[i] <= cap_word[i];
        end
    end

    assign m_valid   = valid_reg;
    assign m_data    = data_reg;
    assign m_idx     = idx_reg;
    assign m_last    = last_reg;
    assign busy      = busy_reg;
    assign desc_done = done_reg;
    assign err_ovr   = ovr_reg;

endmodule
